reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 150 +++++++++++++++
 tb/tb_reset_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: async-assert/sync-deassert, minimum hold, then staggered per-domain release.
// Optional watchdog soft reset is built only when RESET_SEQ_WDOG_EN is defined.
module reset_sequencer #(
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGGER     = 4,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sw_reset_req,
  input  logic               wdog_kick,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               rst_done,
  output logic [1:0]         state,
  output logic [7:0]         soft_rst_cnt,
  output logic               wdog_fired
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned ChW   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int unsigned StagW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

  typedef enum logic [1:0] {
    StAssert  = 2'd0,
    StRelease = 2'd1,
    StRun     = 2'd2
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_rst;
  logic [HoldW-1:0]       hold_cnt;
  logic [ChW-1:0]         ch_idx;
  logic [StagW-1:0]       stag_cnt;
  logic                   wdog_timeout;
  logic                   soft_take;

  assign sync_rst = sync_q[SYNC_STAGES-1];
  assign state    = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  // A request seen in ASSERT only restarts the hold; elsewhere it is a full soft reset.
  always_comb begin
    soft_take = (sw_reset_req && (state_q != StAssert)) || wdog_timeout;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StAssert;
      rst_out      <= '1;
      rst_done     <= 1'b0;
      soft_rst_cnt <= 8'd0;
      hold_cnt     <= '0;
      ch_idx       <= '0;
      stag_cnt     <= '0;
    end else if (soft_take) begin
      state_q  <= StAssert;
      rst_out  <= '1;
      rst_done <= 1'b0;
      hold_cnt <= '0;
      ch_idx   <= '0;
      stag_cnt <= '0;
      if (soft_rst_cnt != 8'hFF) begin
        soft_rst_cnt <= soft_rst_cnt + 8'd1;
      end
    end else begin
      unique case (state_q)
        StAssert: begin
          if (sw_reset_req || sync_rst) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HoldW'(HOLD_CYCLES - 1)) begin
            hold_cnt   <= '0;
            rst_out[0] <= 1'b0;
            stag_cnt   <= '0;
            if (NUM_OUT == 1) begin
              state_q  <= StRun;
              rst_done <= 1'b1;
            end else begin
              state_q <= StRelease;
              ch_idx  <= ChW'(1);
            end
          end else begin
            hold_cnt <= hold_cnt + HoldW'(1);
          end
        end
        StRelease: begin
          if (stag_cnt == StagW'(STAGGER - 1)) begin
            rst_out[ch_idx] <= 1'b0;
            stag_cnt        <= '0;
            if (ch_idx == ChW'(NUM_OUT - 1)) begin
              state_q  <= StRun;
              rst_done <= 1'b1;
            end else begin
              ch_idx <= ch_idx + ChW'(1);
            end
          end else begin
            stag_cnt <= stag_cnt + StagW'(1);
          end
        end
        StRun: begin
        end
        default: begin
          state_q <= StAssert;
        end
      endcase
    end
  end

`ifdef RESET_SEQ_WDOG_EN
  localparam int unsigned WdogW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  logic [WdogW-1:0] wdog_cnt;

  always_comb begin
    wdog_timeout = (state_q == StRun) && (wdog_cnt == WdogW'(WDOG_CYCLES - 1)) && !wdog_kick;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_cnt   <= '0;
      wdog_fired <= 1'b0;
    end else begin
      if (soft_take || (state_q != StRun) || wdog_kick) begin
        wdog_cnt <= '0;
      end else begin
        wdog_cnt <= wdog_cnt + WdogW'(1);
      end
      if (wdog_timeout) begin
        wdog_fired <= 1'b1;
      end
    end
  end
`else
  logic unused_wdog;

  assign unused_wdog  = wdog_kick ^ (WDOG_CYCLES == 0);
  assign wdog_timeout = 1'b0;
  assign wdog_fired   = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: timed vector tables through a scoreboard queue,
// plus hand-written sequences for async reset, held requests and counter saturation.
module tb_reset_sequencer;

`ifdef RESET_SEQ_WDOG_EN
  localparam int unsigned WdogCycles = 8;
`else
  localparam int unsigned WdogCycles = 1024;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       sw_reset_req;
  logic       wdog_kick;
  logic [3:0] rst_out;
  logic       rst_done;
  logic [1:0] state;
  logic [7:0] soft_rst_cnt;
  logic       wdog_fired;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  logic kick_idle = 1'b1;
  int exp_cnt;

  typedef struct {
    string      name;
    int         at;
    logic       sw;
    logic       kick;
    logic [3:0] rst;
    logic       done;
    logic [1:0] st;
    logic [7:0] cnt;
    logic       fired;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  reset_sequencer #(
    .SYNC_STAGES(3),
    .NUM_OUT    (4),
    .HOLD_CYCLES(16),
    .STAGGER    (4),
    .WDOG_CYCLES(WdogCycles)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sw_reset_req(sw_reset_req),
    .wdog_kick   (wdog_kick),
    .rst_out     (rst_out),
    .rst_done    (rst_done),
    .state       (state),
    .soft_rst_cnt(soft_rst_cnt),
    .wdog_fired  (wdog_fired)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL global_timeout edge got %0d exp finish", edge_n);
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(string n, int at, logic sw, logic kick, logic [3:0] rst,
                              logic done, logic [1:0] st, logic [7:0] cnt, logic fired);
    vec_t v;
    v.name = n; v.at = at; v.sw = sw; v.kick = kick; v.rst = rst;
    v.done = done; v.st = st; v.cnt = cnt; v.fired = fired;
    return v;
  endfunction

  task automatic chk(input string name, input string what, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s got %0h exp %0h (edge %0d)", name, what, got, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    edge_n++;
  endtask

  // Reset high for 5 clocks, then released between edges; next posedge is edge 1.
  task automatic release_reset();
    reset = 1'b1;
    repeat (5) @(posedge clock);
    #3;
    reset  = 1'b0;
    edge_n = 0;
  endtask

  task automatic run_tbl();
    vec_t v;
    vec_t e;
    while (tbl.size() > 0) begin
      v = tbl.pop_front();
      if (v.at <= edge_n) begin
        chk(v.name, "table_edge", edge_n, v.at - 1);
        continue;
      end
      sw_reset_req = 1'b0;
      wdog_kick    = kick_idle;
      while (edge_n < v.at - 1) tick();
      sw_reset_req = v.sw;
      wdog_kick    = v.kick;
      sb.push_back(v);
      tick();
      sw_reset_req = 1'b0;
      wdog_kick    = kick_idle;
      e = sb.pop_front();
      chk(e.name, "rst_out", rst_out, e.rst);
      chk(e.name, "rst_done", rst_done, e.done);
      chk(e.name, "state", state, e.st);
      chk(e.name, "soft_rst_cnt", soft_rst_cnt, e.cnt);
      chk(e.name, "wdog_fired", wdog_fired, e.fired);
    end
  endtask

  initial begin
    reset        = 1'b0;
    sw_reset_req = 1'b0;
    wdog_kick    = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("por", "rst_out", rst_out, 4'hF);
    chk("por", "rst_done", rst_done, 1'b0);
    chk("por", "state", state, 2'd0);
    chk("por", "soft_rst_cnt", soft_rst_cnt, 8'd0);
    chk("por", "wdog_fired", wdog_fired, 1'b0);

    // Power-up release: channels at 19/23/27/31.
    release_reset();
    tbl.push_back(mk("boot_e1", 1, 0, 1, 4'hF, 0, 2'd0, 8'd0, 0));
    tbl.push_back(mk("boot_e3", 3, 0, 1, 4'hF, 0, 2'd0, 8'd0, 0));
    tbl.push_back(mk("boot_e18", 18, 0, 1, 4'hF, 0, 2'd0, 8'd0, 0));
    tbl.push_back(mk("boot_e19", 19, 0, 1, 4'hE, 0, 2'd1, 8'd0, 0));
    tbl.push_back(mk("boot_e22", 22, 0, 1, 4'hE, 0, 2'd1, 8'd0, 0));
    tbl.push_back(mk("boot_e23", 23, 0, 1, 4'hC, 0, 2'd1, 8'd0, 0));
    tbl.push_back(mk("boot_e27", 27, 0, 1, 4'h8, 0, 2'd1, 8'd0, 0));
    tbl.push_back(mk("boot_e30", 30, 0, 1, 4'h8, 0, 2'd1, 8'd0, 0));
    tbl.push_back(mk("boot_e31", 31, 0, 1, 4'h0, 1, 2'd2, 8'd0, 0));
    tbl.push_back(mk("boot_e34", 34, 0, 1, 4'h0, 1, 2'd2, 8'd0, 0));
    // Soft reset from RUN sampled at 40: channels at 56/60/64/68.
    tbl.push_back(mk("sw_run_req", 40, 1, 1, 4'hF, 0, 2'd0, 8'd1, 0));
    tbl.push_back(mk("sw_run_e55", 55, 0, 1, 4'hF, 0, 2'd0, 8'd1, 0));
    tbl.push_back(mk("sw_run_e56", 56, 0, 1, 4'hE, 0, 2'd1, 8'd1, 0));
    tbl.push_back(mk("sw_run_e59", 59, 0, 1, 4'hE, 0, 2'd1, 8'd1, 0));
    tbl.push_back(mk("sw_run_e60", 60, 0, 1, 4'hC, 0, 2'd1, 8'd1, 0));
    tbl.push_back(mk("sw_run_e64", 64, 0, 1, 4'h8, 0, 2'd1, 8'd1, 0));
    tbl.push_back(mk("sw_run_e67", 67, 0, 1, 4'h8, 0, 2'd1, 8'd1, 0));
    tbl.push_back(mk("sw_run_e68", 68, 0, 1, 4'h0, 1, 2'd2, 8'd1, 0));
    // Soft reset at 80, then another at 98 while in RELEASE with bit 0 already cleared.
    tbl.push_back(mk("sw2_req", 80, 1, 1, 4'hF, 0, 2'd0, 8'd2, 0));
    tbl.push_back(mk("sw2_e96", 96, 0, 1, 4'hE, 0, 2'd1, 8'd2, 0));
    tbl.push_back(mk("sw2_e97", 97, 0, 1, 4'hE, 0, 2'd1, 8'd2, 0));
    tbl.push_back(mk("sw_rel_req", 98, 1, 1, 4'hF, 0, 2'd0, 8'd3, 0));
    tbl.push_back(mk("sw_rel_e113", 113, 0, 1, 4'hF, 0, 2'd0, 8'd3, 0));
    tbl.push_back(mk("sw_rel_e114", 114, 0, 1, 4'hE, 0, 2'd1, 8'd3, 0));
    tbl.push_back(mk("sw_rel_e118", 118, 0, 1, 4'hC, 0, 2'd1, 8'd3, 0));
    tbl.push_back(mk("sw_rel_e122", 122, 0, 1, 4'h8, 0, 2'd1, 8'd3, 0));
    tbl.push_back(mk("sw_rel_e126", 126, 0, 1, 4'h0, 1, 2'd2, 8'd3, 0));
    run_tbl();

    // Request held over edges 131..150: one count, hold restarts until it drops.
    while (edge_n < 130) tick();
    sw_reset_req = 1'b1;
    repeat (20) tick();
    sw_reset_req = 1'b0;
    chk("held_req", "state", state, 2'd0);
    chk("held_req", "rst_out", rst_out, 4'hF);
    chk("held_req", "soft_rst_cnt", soft_rst_cnt, 8'd4);
    tbl.push_back(mk("held_e165", 165, 0, 1, 4'hF, 0, 2'd0, 8'd4, 0));
    tbl.push_back(mk("held_e166", 166, 0, 1, 4'hE, 0, 2'd1, 8'd4, 0));
    tbl.push_back(mk("held_e170", 170, 0, 1, 4'hC, 0, 2'd1, 8'd4, 0));
    run_tbl();

    // Async reset between clocks mid-RELEASE takes effect with no edge.
    #2 reset = 1'b1;
    #1;
    chk("async_rst", "rst_out", rst_out, 4'hF);
    chk("async_rst", "rst_done", rst_done, 1'b0);
    chk("async_rst", "state", state, 2'd0);
    chk("async_rst", "soft_rst_cnt", soft_rst_cnt, 8'd0);

    release_reset();
    tbl.push_back(mk("reboot_e18", 18, 0, 1, 4'hF, 0, 2'd0, 8'd0, 0));
    tbl.push_back(mk("reboot_e31", 31, 0, 1, 4'h0, 1, 2'd2, 8'd0, 0));
    run_tbl();

    kick_idle = 1'b0;
`ifdef RESET_SEQ_WDOG_EN
    // Kicks every 7 clocks keep RUN; last kick at 56 times out at 64.
    tbl.push_back(mk("wd_k35", 35, 0, 1, 4'h0, 1, 2'd2, 8'd0, 0));
    tbl.push_back(mk("wd_e41", 41, 0, 0, 4'h0, 1, 2'd2, 8'd0, 0));
    tbl.push_back(mk("wd_k42", 42, 0, 1, 4'h0, 1, 2'd2, 8'd0, 0));
    tbl.push_back(mk("wd_e48", 48, 0, 0, 4'h0, 1, 2'd2, 8'd0, 0));
    tbl.push_back(mk("wd_k49", 49, 0, 1, 4'h0, 1, 2'd2, 8'd0, 0));
    tbl.push_back(mk("wd_e55", 55, 0, 0, 4'h0, 1, 2'd2, 8'd0, 0));
    tbl.push_back(mk("wd_k56", 56, 0, 1, 4'h0, 1, 2'd2, 8'd0, 0));
    tbl.push_back(mk("wd_e63", 63, 0, 0, 4'h0, 1, 2'd2, 8'd0, 0));
    tbl.push_back(mk("wd_fire", 64, 0, 0, 4'hF, 0, 2'd0, 8'd1, 1));
    run_tbl();
    kick_idle = 1'b1;
    tbl.push_back(mk("wd_sticky", 92, 0, 1, 4'h0, 1, 2'd2, 8'd1, 1));
    run_tbl();
    exp_cnt = 1;
`else
    tbl.push_back(mk("no_wdog", 80, 0, 0, 4'h0, 1, 2'd2, 8'd0, 0));
    run_tbl();
    kick_idle = 1'b1;
    exp_cnt = 0;
`endif

    // 260 soft resets, each issued once the block is back in RELEASE.
    wdog_kick = kick_idle;
    for (int i = 0; i < 260; i++) begin
      int budget;
      sw_reset_req = 1'b1;
      tick();
      sw_reset_req = 1'b0;
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      chk("saturate", "soft_rst_cnt", soft_rst_cnt, exp_cnt);
      budget = 0;
      while (state != 2'd1 && budget < 40) begin
        tick();
        budget++;
      end
      if (state != 2'd1) begin
        chk("saturate_wait", "state", state, 2'd1);
        break;
      end
    end
    chk("saturate_final", "soft_rst_cnt", soft_rst_cnt, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
